// File: rtl/wb_tia_audio_if.sv
// rtl/wb_tia_audio_if.sv - Wishbone slave bus bundle for wb_tia_audio
// Master drives: stb_i (strobe), we_i (write enable), adr_i (address), dat_i (write data).
// Slave drives:  ack_o (registered acknowledge), dat_o (read data, valid with ack_o).
interface wb_tia_audio_if #(
  parameter int WB_DATA_WIDTH = 8,
  parameter int WB_ADDR_WIDTH = 7
);
  logic                     stb_i;
  logic                     we_i;
  logic [WB_ADDR_WIDTH-1:0] adr_i;
  logic [WB_DATA_WIDTH-1:0] dat_i;
  logic                     ack_o;
  logic [WB_DATA_WIDTH-1:0] dat_o;

  modport master (output stb_i, we_i, adr_i, dat_i, input ack_o, dat_o);
  modport slave  (input stb_i, we_i, adr_i, dat_i, output ack_o, dat_o);
endinterface

// File: rtl/wb_tia_audio.sv
// rtl/wb_tia_audio.sv - multi-channel TIA-style tone/noise generator with mixer and PWM
// Ports: clk_i (system clock), rst_i (sync active-high reset), bus (Wishbone slave:
// per-channel AUDC/AUDF/AUDV/STATUS at adr_i[1:0], channel at adr_i[W-1:2]),
// sample_o (mixed sample), sample_valid_o (pulse on sample update), pwm_o (PWM of sample_o).
module wb_tia_audio #(
  parameter int WB_DATA_WIDTH = 8,
  parameter int WB_ADDR_WIDTH = 7,
  parameter int NUM_CHANNELS  = 2,
  parameter int AUD_CLK_DIV   = 509,
  localparam int MIX_WIDTH    = (NUM_CHANNELS == 1) ? 4 : 4 + $clog2(NUM_CHANNELS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  wb_tia_audio_if.slave        bus,
  output logic [MIX_WIDTH-1:0] sample_o,
  output logic                 sample_valid_o,
  output logic                 pwm_o
);
  localparam int PRE_W = $clog2(AUD_CLK_DIV);
  localparam int CH_W  = WB_ADDR_WIDTH - 2;

  logic [PRE_W-1:0]         pre_q, pre_d;
  logic                     tick;
  logic                     tick_q, tick_d;
  logic                     ack_q, ack_d;
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
  logic [MIX_WIDTH-1:0]     sample_q, sample_d, pwm_cnt_q, pwm_cnt_d, sum;
  logic                     valid_q, valid_d;

  logic [3:0] audc_q [NUM_CHANNELS], audc_d [NUM_CHANNELS];
  logic [4:0] audf_q [NUM_CHANNELS], audf_d [NUM_CHANNELS];
  logic [3:0] audv_q [NUM_CHANNELS], audv_d [NUM_CHANNELS];
  logic [4:0] fdiv_q [NUM_CHANNELS], fdiv_d [NUM_CHANNELS];
  logic [3:0] p4_q   [NUM_CHANNELS], p4_d   [NUM_CHANNELS];
  logic [4:0] p5_q   [NUM_CHANNELS], p5_d   [NUM_CHANNELS];
  logic [8:0] p9_q   [NUM_CHANNELS], p9_d   [NUM_CHANNELS];
  logic [1:0] d3_q   [NUM_CHANNELS], d3_d   [NUM_CHANNELS];
  logic [3:0] d15_q  [NUM_CHANNELS], d15_d  [NUM_CHANNELS];
  logic [5:0] d45_q  [NUM_CHANNELS], d45_d  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] wave_q, wave_d, wave_tick;

  // Only the low five data bits ever reach a register.
  logic unused_dat;
  assign unused_dat = ^bus.dat_i[WB_DATA_WIDTH-1:5];

  function automatic logic [3:0] step4(input logic [3:0] x);
    return {x[0] ^ x[1], x[3:1]};
  endfunction
  function automatic logic [4:0] step5(input logic [4:0] x);
    return {x[0] ^ x[2], x[4:1]};
  endfunction
  function automatic logic [8:0] step9(input logic [8:0] x);
    return {x[0] ^ x[4], x[8:1]};
  endfunction

  // Register file access; reads see the pre-write values of the strobe cycle.
  always_comb begin
    ack_d  = bus.stb_i;
    dat_d  = '0;
    audc_d = audc_q;
    audf_d = audf_q;
    audv_d = audv_q;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (bus.stb_i && (bus.adr_i[WB_ADDR_WIDTH-1:2] == CH_W'(c))) begin
        if (bus.we_i) begin
          case (bus.adr_i[1:0])
            2'd0:    audc_d[c] = bus.dat_i[3:0];
            2'd1:    audf_d[c] = bus.dat_i[4:0];
            2'd2:    audv_d[c] = bus.dat_i[3:0];
            default: ;
          endcase
        end else begin
          case (bus.adr_i[1:0])
            2'd0:    dat_d[3:0] = audc_q[c];
            2'd1:    dat_d[4:0] = audf_q[c];
            2'd2:    dat_d[3:0] = audv_q[c];
            default: dat_d[0]   = wave_q[c];
          endcase
        end
      end
    end
  end

  // Prescaler, frequency dividers and waveform generators.
  always_comb begin
    tick      = (pre_q == PRE_W'(AUD_CLK_DIV - 1));
    pre_d     = tick ? '0 : pre_q + PRE_W'(1);
    tick_d    = tick;
    wave_tick = '0;
    wave_d    = wave_q;
    fdiv_d    = fdiv_q;
    p4_d      = p4_q;
    p5_d      = p5_q;
    p9_d      = p9_q;
    d3_d      = d3_q;
    d15_d     = d15_q;
    d45_d     = d45_q;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (tick) begin
        if (fdiv_q[c] == audf_q[c]) begin
          wave_tick[c] = 1'b1;
          fdiv_d[c]    = '0;
        end else begin
          fdiv_d[c] = fdiv_q[c] + 5'd1;
        end
      end
      if (wave_tick[c]) begin
        d3_d[c]  = (d3_q[c] == 2'd2)   ? '0 : d3_q[c] + 2'd1;
        d15_d[c] = (d15_q[c] == 4'd14) ? '0 : d15_q[c] + 4'd1;
        d45_d[c] = (d45_q[c] == 6'd44) ? '0 : d45_q[c] + 6'd1;
        case (audc_q[c])
          4'h0, 4'hB: wave_d[c] = 1'b1;
          4'h1: begin
            wave_d[c] = p4_q[c][0];
            p4_d[c]   = step4(p4_q[c]);
          end
          4'h2: begin
            wave_d[c] = p4_q[c][0];
            if (d15_q[c] == 4'd14) p4_d[c] = step4(p4_q[c]);
          end
          4'h3: begin
            wave_d[c] = p4_q[c][0];
            p5_d[c]   = step5(p5_q[c]);
            if (p5_q[c][0]) p4_d[c] = step4(p4_q[c]);
          end
          4'h4, 4'h5: wave_d[c] = ~wave_q[c];
          4'h6, 4'hA: if (d15_q[c] == 4'd14) wave_d[c] = ~wave_q[c];
          4'h7: begin
            p5_d[c] = step5(p5_q[c]);
            if (p5_q[c][0]) wave_d[c] = ~wave_q[c];
          end
          4'h8: begin
            wave_d[c] = p9_q[c][0];
            p9_d[c]   = step9(p9_q[c]);
          end
          4'h9: begin
            wave_d[c] = p5_q[c][0];
            p5_d[c]   = step5(p5_q[c]);
          end
          4'hC, 4'hD: if (d3_q[c] == 2'd2) wave_d[c] = ~wave_q[c];
          4'hE: if (d45_q[c] == 6'd44) wave_d[c] = ~wave_q[c];
          default: begin
            p5_d[c] = step5(p5_q[c]);
            if ((d3_q[c] == 2'd2) && p5_q[c][0]) wave_d[c] = ~wave_q[c];
          end
        endcase
      end
    end
  end

  // Mixer runs one cycle behind the tick so it sees the freshly updated wave bits.
  always_comb begin
    sum = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (wave_q[c]) sum = sum + MIX_WIDTH'(audv_q[c]);
    end
    sample_d  = tick_q ? sum : sample_q;
    valid_d   = tick_q;
    pwm_cnt_d = pwm_cnt_q + MIX_WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_q     <= '0;
      tick_q    <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      pwm_cnt_q <= '0;
      wave_q    <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        audc_q[c] <= '0;
        audf_q[c] <= '0;
        audv_q[c] <= '0;
        fdiv_q[c] <= '0;
        p4_q[c]   <= '1;
        p5_q[c]   <= '1;
        p9_q[c]   <= '1;
        d3_q[c]   <= '0;
        d15_q[c]  <= '0;
        d45_q[c]  <= '0;
      end
    end else begin
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      pwm_cnt_q <= pwm_cnt_d;
      wave_q    <= wave_d;
      audc_q    <= audc_d;
      audf_q    <= audf_d;
      audv_q    <= audv_d;
      fdiv_q    <= fdiv_d;
      p4_q      <= p4_d;
      p5_q      <= p5_d;
      p9_q      <= p9_d;
      d3_q      <= d3_d;
      d15_q     <= d15_d;
      d45_q     <= d45_d;
    end
  end

  assign bus.ack_o      = ack_q;
  assign bus.dat_o      = dat_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign pwm_o          = (pwm_cnt_q < sample_q);
endmodule

// File: tb/tb_wb_tia_audio.sv
// tb/tb_wb_tia_audio.sv - self-checking bench for wb_tia_audio
module tb_wb_tia_audio;
  localparam int NCH  = 2;
  localparam int DIV  = 4;
  localparam int MIXW = 5;
  localparam int DW   = 8;
  localparam int AW   = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic [MIXW-1:0] sample_o;
  logic            sample_valid_o;
  logic            pwm_o;

  wb_tia_audio_if #(.WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW)) bus ();

  wb_tia_audio #(
    .WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW), .NUM_CHANNELS(NCH), .AUD_CLK_DIV(DIV)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus),
    .sample_o(sample_o), .sample_valid_o(sample_valid_o), .pwm_o(pwm_o)
  );

  always #5 clk = ~clk;

  int n_cmp, n_err, cyc;
  int log_q[$];
  int stamp_q[$];

  // Reference model state
  int m_audc[NCH], m_audf[NCH], m_audv[NCH], m_fdiv[NCH], m_wave[NCH];
  int m_p4[NCH], m_p5[NCH], m_p9[NCH], m_nwt[NCH];
  int m_pre, m_sample, m_pwm, m_dat;
  bit m_tick_d1, m_valid, m_ack, m_rd;

  function automatic int lfsr_step(int x, int n, int tap);
    int fb;
    fb = (x ^ (x >> tap)) & 1;
    return (x >> 1) | (fb << (n - 1));
  endfunction

  function automatic void wave_event(int c);
    int n;
    m_nwt[c]++;
    n = m_nwt[c];
    case (m_audc[c])
      0, 11: m_wave[c] = 1;
      1: begin m_wave[c] = m_p4[c] & 1; m_p4[c] = lfsr_step(m_p4[c], 4, 1); end
      2: begin m_wave[c] = m_p4[c] & 1; if (n % 15 == 0) m_p4[c] = lfsr_step(m_p4[c], 4, 1); end
      3: begin
        m_wave[c] = m_p4[c] & 1;
        if (m_p5[c] & 1) m_p4[c] = lfsr_step(m_p4[c], 4, 1);
        m_p5[c] = lfsr_step(m_p5[c], 5, 2);
      end
      4, 5: m_wave[c] = 1 - m_wave[c];
      6, 10: if (n % 15 == 0) m_wave[c] = 1 - m_wave[c];
      7: begin
        if (m_p5[c] & 1) m_wave[c] = 1 - m_wave[c];
        m_p5[c] = lfsr_step(m_p5[c], 5, 2);
      end
      8: begin m_wave[c] = m_p9[c] & 1; m_p9[c] = lfsr_step(m_p9[c], 9, 4); end
      9: begin m_wave[c] = m_p5[c] & 1; m_p5[c] = lfsr_step(m_p5[c], 5, 2); end
      12, 13: if (n % 3 == 0) m_wave[c] = 1 - m_wave[c];
      14: if (n % 45 == 0) m_wave[c] = 1 - m_wave[c];
      default: begin
        if ((n % 3 == 0) && (m_p5[c] & 1)) m_wave[c] = 1 - m_wave[c];
        m_p5[c] = lfsr_step(m_p5[c], 5, 2);
      end
    endcase
  endfunction

  function automatic void model_edge();
    int ch, rg, rdv, sum;
    bit tk;
    if (rst) begin
      m_pre = 0; m_sample = 0; m_pwm = 0; m_dat = 0;
      m_tick_d1 = 0; m_valid = 0; m_ack = 0; m_rd = 0;
      for (int c = 0; c < NCH; c++) begin
        m_audc[c] = 0; m_audf[c] = 0; m_audv[c] = 0; m_fdiv[c] = 0; m_wave[c] = 0;
        m_p4[c] = 15; m_p5[c] = 31; m_p9[c] = 511; m_nwt[c] = 0;
      end
    end else begin
      ch = int'(bus.adr_i[AW-1:2]);
      rg = int'(bus.adr_i[1:0]);
      rdv = 0;
      if (ch < NCH) begin
        case (rg)
          0: rdv = m_audc[ch];
          1: rdv = m_audf[ch];
          2: rdv = m_audv[ch];
          default: rdv = m_wave[ch];
        endcase
      end
      m_ack = bus.stb_i;
      m_rd  = bus.stb_i && !bus.we_i;
      m_dat = m_rd ? rdv : 0;
      sum = 0;
      for (int c = 0; c < NCH; c++) sum += m_wave[c] ? m_audv[c] : 0;
      m_valid = m_tick_d1;
      if (m_tick_d1) m_sample = sum;
      m_pwm = (m_pwm + 1) % 32;
      tk = (m_pre == DIV - 1);
      m_tick_d1 = tk;
      m_pre = tk ? 0 : m_pre + 1;
      if (tk) begin
        for (int c = 0; c < NCH; c++) begin
          if (m_fdiv[c] == m_audf[c]) begin
            m_fdiv[c] = 0;
            wave_event(c);
          end else begin
            m_fdiv[c] = (m_fdiv[c] + 1) % 32;
          end
        end
      end
      if (bus.stb_i && bus.we_i && ch < NCH) begin
        case (rg)
          0: m_audc[ch] = int'(bus.dat_i) & 15;
          1: m_audf[ch] = int'(bus.dat_i) & 31;
          2: m_audv[ch] = int'(bus.dat_i) & 15;
          default: ;
        endcase
      end
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    if (sample_valid_o === 1'b1) begin
      log_q.push_back(int'(sample_o));
      stamp_q.push_back(cyc);
    end
  endtask

  task automatic do_reset(int n);
    rst = 1'b1; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    repeat (n) cycle();
    rst = 1'b0;
    log_q.delete(); stamp_q.delete();
  endtask

  task automatic wb_write(int ch, int rg, int d);
    bus.stb_i = 1'b1; bus.we_i = 1'b1;
    bus.adr_i = AW'((ch << 2) | rg); bus.dat_i = DW'(d);
    cycle();
    bus.stb_i = 1'b0; bus.we_i = 1'b0;
  endtask

  task automatic wb_read(int ch, int rg, output logic [DW-1:0] d, output logic a);
    bus.stb_i = 1'b1; bus.we_i = 1'b0; bus.adr_i = AW'((ch << 2) | rg);
    cycle();
    d = bus.dat_o; a = bus.ack_o;
    bus.stb_i = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (sample_valid_o === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] d; logic a; bit ok;
    do_reset(2);
    wb_write(0, 0, 4); wb_write(0, 2, 15); wb_write(1, 2, 9);
    repeat (21) cycle();
    rst = 1'b1;
    repeat (3) cycle();
    n_cmp++; if (sample_o !== 0) begin n_err++; $display("FAIL rst_sample got=%0d exp=0", sample_o); end
    n_cmp++; if (sample_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", sample_valid_o); end
    n_cmp++; if (bus.ack_o !== 1'b0) begin n_err++; $display("FAIL rst_ack got=%b exp=0", bus.ack_o); end
    n_cmp++; if (bus.dat_o !== 0) begin n_err++; $display("FAIL rst_dat got=%0h exp=0", bus.dat_o); end
    n_cmp++; if (pwm_o !== 1'b0) begin n_err++; $display("FAIL rst_pwm got=%b exp=0", pwm_o); end
    rst = 1'b0;
    wb_read(0, 3, d, a);
    n_cmp++; if (d !== 0) begin n_err++; $display("FAIL rst_status got=%0h exp=0", d); end
    for (int r = 0; r < 3; r++) begin
      wb_read(0, r, d, a);
      n_cmp++; if (d !== 0) begin n_err++; $display("FAIL rst_reg%0d got=%0h exp=0", r, d); end
    end
    wb_write(0, 0, 1); wb_write(0, 2, 15);
    wait_valid(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rst_first_valid got=timeout exp=pulse"); end
    n_cmp++; if (sample_o !== 15) begin n_err++; $display("FAIL rst_first_wave got=%0d exp=15", sample_o); end
    wb_read(0, 3, d, a);
    n_cmp++; if (d !== 1) begin n_err++; $display("FAIL rst_status_wave got=%0h exp=1", d); end
  endtask

  task automatic test_square();
    int bad_alt, bad_per;
    do_reset(2);
    wb_write(0, 0, 4); wb_write(0, 2, 15);
    repeat (40) cycle();
    bad_alt = 0; bad_per = 0;
    for (int i = 2; i < log_q.size(); i++) begin
      if ((log_q[i] + log_q[i-1] != 15) || (log_q[i] != 0 && log_q[i] != 15)) bad_alt++;
      if (stamp_q[i] - stamp_q[i-1] != 4) bad_per++;
    end
    n_cmp++; if (log_q.size() < 8) begin n_err++; $display("FAIL sq_count got=%0d exp>=8", log_q.size()); end
    n_cmp++; if (bad_alt != 0) begin n_err++; $display("FAIL sq_alternate got=%0d bad exp=0", bad_alt); end
    n_cmp++; if (bad_per != 0) begin n_err++; $display("FAIL sq_period got=%0d bad exp=0", bad_per); end
  endtask

  task automatic test_divider();
    int chg[$]; int bad;
    do_reset(2);
    wb_write(0, 0, 4); wb_write(0, 1, 3); wb_write(0, 2, 15);
    repeat (37) cycle();
    wb_write(0, 1, 3);
    repeat (9) cycle();
    wb_write(0, 1, 3);
    repeat (80) cycle();
    for (int i = 1; i < log_q.size(); i++) if (log_q[i] != log_q[i-1]) chg.push_back(i);
    bad = 0;
    for (int k = 2; k < chg.size(); k++) if (chg[k] - chg[k-1] != 4) bad++;
    n_cmp++; if (chg.size() < 6) begin n_err++; $display("FAIL div_changes got=%0d exp>=6", chg.size()); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL div_spacing got=%0d bad exp=0", bad); end
  endtask

  task automatic test_noise(int mode, int period);
    int s, bad, ones;
    do_reset(2);
    wb_write(0, 0, mode); wb_write(0, 2, 15);
    repeat ((2 * period + 8) * DIV + 8) cycle();
    s = 4; bad = 0; ones = 0;
    n_cmp++;
    if (log_q.size() < s + 2 * period) begin
      n_err++; $display("FAIL noise%0d_count got=%0d exp>=%0d", mode, log_q.size(), s + 2 * period);
    end else begin
      for (int i = s; i < s + period; i++) begin
        if (log_q[i] != log_q[i + period]) bad++;
        if (log_q[i] == 15) ones++;
      end
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL noise%0d_period got=%0d bad exp=0", mode, bad); end
    n_cmp++; if (ones != (period + 1) / 2) begin
      n_err++; $display("FAIL noise%0d_ones got=%0d exp=%0d", mode, ones, (period + 1) / 2);
    end
  endtask

  task automatic test_mix_pwm();
    int hi;
    do_reset(2);
    wb_write(0, 2, 15); wb_write(1, 2, 9);
    repeat (12) cycle();
    n_cmp++; if (sample_o !== 24) begin n_err++; $display("FAIL mix_sum got=%0d exp=24", sample_o); end
    hi = 0;
    for (int i = 0; i < 32; i++) begin
      cycle();
      if (pwm_o === 1'b1) hi++;
    end
    n_cmp++; if (hi != 24) begin n_err++; $display("FAIL pwm_duty got=%0d exp=24", hi); end
  endtask

  task automatic test_bus();
    logic [DW-1:0] d; logic a;
    do_reset(2);
    wb_write(0, 1, 8'hFF);
    n_cmp++; if (bus.ack_o !== 1'b1) begin n_err++; $display("FAIL bus_wr_ack got=%b exp=1", bus.ack_o); end
    wb_read(0, 1, d, a);
    n_cmp++; if (d !== 8'h1F) begin n_err++; $display("FAIL bus_audf got=%0h exp=1f", d); end
    wb_write(0, 0, 8'hFF); wb_read(0, 0, d, a);
    n_cmp++; if (d !== 8'h0F) begin n_err++; $display("FAIL bus_audc got=%0h exp=0f", d); end
    wb_write(0, 2, 8'hA7); wb_read(0, 2, d, a);
    n_cmp++; if (d !== 8'h07) begin n_err++; $display("FAIL bus_audv got=%0h exp=07", d); end
    wb_write(NCH, 1, 8'h05);
    n_cmp++; if (bus.ack_o !== 1'b1) begin n_err++; $display("FAIL bus_oor_ack got=%b exp=1", bus.ack_o); end
    cycle();
    n_cmp++; if (bus.ack_o !== 1'b0) begin n_err++; $display("FAIL bus_ack_drop got=%b exp=0", bus.ack_o); end
    wb_read(NCH, 1, d, a);
    n_cmp++; if (d !== 0 || a !== 1'b1) begin n_err++; $display("FAIL bus_oor_read got=%0h/%b exp=0/1", d, a); end
    wb_read(0, 1, d, a);
    n_cmp++; if (d !== 8'h1F) begin n_err++; $display("FAIL bus_oor_alias0 got=%0h exp=1f", d); end
    wb_read(1, 1, d, a);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL bus_oor_alias1 got=%0h exp=00", d); end
    bus.stb_i = 1'b1; bus.we_i = 1'b0; bus.adr_i = AW'(1);
    cycle();
    n_cmp++; if (bus.ack_o !== 1'b1) begin n_err++; $display("FAIL b2b_ack1 got=%b exp=1", bus.ack_o); end
    bus.adr_i = AW'(0);
    cycle();
    n_cmp++; if (bus.ack_o !== 1'b1 || bus.dat_o !== 8'h0F) begin
      n_err++; $display("FAIL b2b_ack2 got=%b/%0h exp=1/0f", bus.ack_o, bus.dat_o);
    end
    bus.stb_i = 1'b0;
    cycle();
    rst = 1'b1; bus.stb_i = 1'b1;
    cycle();
    n_cmp++; if (bus.ack_o !== 1'b0) begin n_err++; $display("FAIL rst_strobe_ack got=%b exp=0", bus.ack_o); end
    cycle();
    n_cmp++; if (bus.ack_o !== 1'b0) begin n_err++; $display("FAIL rst_strobe_ack2 got=%b exp=0", bus.ack_o); end
    bus.stb_i = 1'b0; rst = 1'b0;
  endtask

  task automatic test_random();
    int ch, rg;
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      bus.stb_i = ($urandom_range(0, 2) == 0);
      bus.we_i = 1'($urandom_range(0, 1));
      ch = int'($urandom_range(0, NCH));
      rg = int'($urandom_range(0, 3));
      bus.adr_i = AW'((ch << 2) | rg);
      bus.dat_i = (rg == 1 && $urandom_range(0, 3) != 0) ? DW'($urandom_range(0, 3)) : DW'($urandom_range(0, 255));
      cycle();
      n_cmp++; if (sample_o !== MIXW'(m_sample)) begin
        n_err++; $display("FAIL rnd_sample cyc=%0d got=%0d exp=%0d", cyc, sample_o, m_sample);
      end
      n_cmp++; if (sample_valid_o !== m_valid) begin
        n_err++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, sample_valid_o, m_valid);
      end
      n_cmp++; if (bus.ack_o !== m_ack) begin
        n_err++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", cyc, bus.ack_o, m_ack);
      end
      n_cmp++; if (pwm_o !== (m_pwm < m_sample)) begin
        n_err++; $display("FAIL rnd_pwm cyc=%0d got=%b exp=%b", cyc, pwm_o, m_pwm < m_sample);
      end
      if (m_rd) begin
        n_cmp++; if (bus.dat_o !== DW'(m_dat)) begin
          n_err++; $display("FAIL rnd_dat cyc=%0d got=%0h exp=%0h", cyc, bus.dat_o, m_dat);
        end
      end
    end
    rst = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    rst = 1'b1;
    bus.stb_i = 1'b0; bus.we_i = 1'b0; bus.adr_i = '0; bus.dat_i = '0;
    test_reset();
    test_square();
    test_divider();
    test_noise(1, 15);
    test_noise(9, 31);
    test_noise(8, 511);
    test_mix_pwm();
    test_bus();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
